// File: rtl/button_event_ctrl_if.sv
// Event delivery channel from the button sequencer to the control logic.
// The master drives one event per valid/ready handshake.
interface button_event_ctrl_if #(
  parameter int IDX_WIDTH = 2
) ();
  logic                 evt_valid;
  logic                 evt_ready;
  logic [IDX_WIDTH-1:0] evt_btn;
  logic [1:0]           evt_type;

  modport master (output evt_valid, output evt_btn, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_btn, input evt_type, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// Per-button PRESS/LONG/REPEAT/RELEASE sequencer with one pending slot per
// button and a round-robin arbiter feeding a single registered event channel.
module button_event_ctrl #(
  parameter int WIDTH         = 3,
  parameter int IDX_WIDTH     = 2,
  parameter int LONG_TIMEOUT  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_WIDTH     = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     btn_level,
  button_event_ctrl_if.master  evt,
  output logic [WIDTH-1:0]     overflow,
  input  logic [WIDTH-1:0]     clr_overflow
);

  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_t;

  state_t               state     [WIDTH];
  state_t               state_nxt [WIDTH];
  logic [CNT_WIDTH-1:0] cnt       [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_nxt   [WIDTH];
  logic [WIDTH-1:0]     emit;
  logic [1:0]           etype     [WIDTH];

  logic [WIDTH-1:0]     pend;
  logic [1:0]           ptype     [WIDTH];
  logic [WIDTH-1:0]     take;
  logic [WIDTH-1:0]     drop;
  logic [IDX_WIDTH-1:0] last_grant;

  logic                 out_valid;
  logic [IDX_WIDTH-1:0] out_btn;
  logic [1:0]           out_type;
  logic                 load_out;

  logic                 sel_found, hi_found;
  logic [IDX_WIDTH-1:0] sel_idx, hi_idx, lo_idx;
  logic [1:0]           sel_type, hi_type, lo_type;

  assign evt.evt_valid = out_valid;
  assign evt.evt_btn   = out_btn;
  assign evt.evt_type  = out_type;
  assign load_out      = !out_valid || evt.evt_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // RELEASE is checked first so it wins over a coinciding LONG/REPEAT point.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      emit[i]      = 1'b0;
      etype[i]     = EVT_PRESS;
      case (state[i])
        IDLE: begin
          cnt_nxt[i] = '0;
          if (btn_level[i]) begin
            emit[i]      = 1'b1;
            etype[i]     = EVT_PRESS;
            state_nxt[i] = HELD;
          end
        end
        HELD: begin
          if (!btn_level[i]) begin
            emit[i]      = 1'b1;
            etype[i]     = EVT_RELEASE;
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_WIDTH'(LONG_TIMEOUT - 1)) begin
            emit[i]      = 1'b1;
            etype[i]     = EVT_LONG;
            state_nxt[i] = RPT;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        RPT: begin
          if (!btn_level[i]) begin
            emit[i]      = 1'b1;
            etype[i]     = EVT_RELEASE;
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_WIDTH'(REPEAT_PERIOD - 1)) begin
            emit[i]    = 1'b1;
            etype[i]   = EVT_REPEAT;
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        default: begin
          state_nxt[i] = IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Round robin: lowest pending index above last_grant, else lowest pending overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    hi_type  = '0;
    lo_idx   = '0;
    lo_type  = '0;
    sel_found = 1'b0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (pend[j]) begin
        sel_found = 1'b1;
        lo_idx    = IDX_WIDTH'(j);
        lo_type   = ptype[j];
        if (IDX_WIDTH'(j) > last_grant) begin
          hi_found = 1'b1;
          hi_idx   = IDX_WIDTH'(j);
          hi_type  = ptype[j];
        end
      end
    end
    sel_idx  = hi_found ? hi_idx  : lo_idx;
    sel_type = hi_found ? hi_type : lo_type;
    for (int j = 0; j < WIDTH; j++) begin
      take[j] = load_out && sel_found && (sel_idx == IDX_WIDTH'(j));
      drop[j] = emit[j] && pend[j] && !take[j];
    end
  end

  // A slot being drained this cycle may be refilled; a full, idle slot drops the new event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      overflow   <= '0;
      last_grant <= IDX_WIDTH'(WIDTH - 1);
      out_valid  <= 1'b0;
      out_btn    <= '0;
      out_type   <= '0;
      for (int i = 0; i < WIDTH; i++) ptype[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (emit[i] && (!pend[i] || take[i])) begin
          pend[i]  <= 1'b1;
          ptype[i] <= etype[i];
        end else if (take[i]) begin
          pend[i] <= 1'b0;
        end
      end
      overflow <= (overflow & ~clr_overflow) | drop;
      if (load_out) begin
        out_valid <= sel_found;
        if (sel_found) begin
          out_btn    <= sel_idx;
          out_type   <= sel_type;
          last_grant <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: logs every handshake with its cycle
// number and compares the log against hand-computed event lists.
module tb_button_event_ctrl;

  localparam int WIDTH = 3;
  localparam int IDX_WIDTH = 2;
  localparam logic [1:0] PRESS = 2'd0, REL = 2'd1, LONG = 2'd2, REP = 2'd3;

  typedef struct {
    logic [1:0] btn;
    logic [1:0] typ;
    int         cyc;
  } evt_rec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] btn_level = '0;
  logic [WIDTH-1:0] overflow;
  logic [WIDTH-1:0] clr_overflow = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0, e1, x;

  evt_rec_t log_q [$];
  evt_rec_t exp_q [$];

  button_event_ctrl_if #(.IDX_WIDTH(IDX_WIDTH)) evt_if ();

  button_event_ctrl #(
    .WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH),
    .LONG_TIMEOUT(8), .REPEAT_PERIOD(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_level(btn_level), .evt(evt_if.master),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Record each handshake that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
      log_q.push_back('{btn: evt_if.evt_btn, typ: evt_if.evt_type, cyc: cyc});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] lvl, input logic rdy, input logic [WIDTH-1:0] clr);
    btn_level = lvl;
    evt_if.evt_ready = rdy;
    clr_overflow = clr;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic expectEvt(input logic [1:0] btn, input logic [1:0] typ, input int c);
    exp_q.push_back('{btn: btn, typ: typ, cyc: c});
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s_%0d_btn_type", tag, i),
                  {28'd0, log_q[i].btn, log_q[i].typ}, {28'd0, exp_q[i].btn, exp_q[i].typ});
      checkOutput($sformatf("%s_%0d_cycle", tag, i), log_q[i].cyc, exp_q[i].cyc);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;
    tick(2);
    checkOutput("reset_valid", evt_if.evt_valid, 0);
    checkOutput("reset_btn", evt_if.evt_btn, 0);
    checkOutput("reset_type", evt_if.evt_type, 0);
    checkOutput("reset_overflow", overflow, 0);
    reset = 1'b0;

    // Tap on button 0
    applyReset();
    applyStimulus(3'b001, 1'b1, 3'b000); e0 = cyc + 1;
    tick(3); applyStimulus(3'b000, 1'b1, 3'b000); tick(5);
    expectEvt(0, PRESS, e0 + 1); expectEvt(0, REL, e0 + 4);
    compareLog("tap");
    checkOutput("tap_overflow", overflow, 0);

    // Long hold on button 1, release on a repeat point
    applyReset();
    applyStimulus(3'b010, 1'b1, 3'b000); e0 = cyc + 1;
    tick(20); applyStimulus(3'b000, 1'b1, 3'b000); tick(4);
    expectEvt(1, PRESS, e0 + 1); expectEvt(1, LONG, e0 + 9);
    expectEvt(1, REP, e0 + 13); expectEvt(1, REP, e0 + 17);
    expectEvt(1, REL, e0 + 21);
    compareLog("hold");

    // Round robin, two simultaneous rounds
    applyReset();
    applyStimulus(3'b111, 1'b1, 3'b000); e0 = cyc + 1;
    tick(3); applyStimulus(3'b000, 1'b1, 3'b000); tick(7);
    applyStimulus(3'b111, 1'b1, 3'b000); e1 = cyc + 1;
    tick(3); applyStimulus(3'b000, 1'b1, 3'b000); tick(7);
    for (int b = 0; b < 3; b++) expectEvt(2'(b), PRESS, e0 + 1 + b);
    for (int b = 0; b < 3; b++) expectEvt(2'(b), REL, e0 + 4 + b);
    for (int b = 0; b < 3; b++) expectEvt(2'(b), PRESS, e1 + 1 + b);
    for (int b = 0; b < 3; b++) expectEvt(2'(b), REL, e1 + 4 + b);
    compareLog("rr");

    // Backpressure on button 2: two-deep buffer then drop
    applyReset();
    applyStimulus(3'b100, 1'b0, 3'b000);
    tick(2); applyStimulus(3'b000, 1'b0, 3'b000);
    tick(2); applyStimulus(3'b100, 1'b0, 3'b000);
    tick(2); applyStimulus(3'b000, 1'b0, 3'b000);
    tick(2);
    checkOutput("bp_overflow", overflow, 3'b100);
    checkOutput("bp_valid", evt_if.evt_valid, 1);
    checkOutput("bp_btn", evt_if.evt_btn, 2);
    checkOutput("bp_type", evt_if.evt_type, PRESS);
    tick(2);
    checkOutput("bp_stable_valid", evt_if.evt_valid, 1);
    checkOutput("bp_stable_btn", evt_if.evt_btn, 2);
    checkOutput("bp_stable_type", evt_if.evt_type, PRESS);
    applyStimulus(3'b000, 1'b1, 3'b000); x = cyc;
    tick(3);
    expectEvt(2, PRESS, x); expectEvt(2, REL, x + 1);
    compareLog("bp");
    checkOutput("bp_drained", evt_if.evt_valid, 0);
    checkOutput("bp_overflow_kept", overflow, 3'b100);
    applyStimulus(3'b000, 1'b1, 3'b100); tick(1);
    applyStimulus(3'b000, 1'b1, 3'b000);
    checkOutput("bp_overflow_clr", overflow, 3'b000);

    // Overflow set and clear in the same cycle
    applyStimulus(3'b100, 1'b0, 3'b000);
    tick(2); applyStimulus(3'b000, 1'b0, 3'b000);
    tick(2); applyStimulus(3'b100, 1'b0, 3'b000);
    tick(2);
    checkOutput("col_overflow_set", overflow, 3'b100);
    applyStimulus(3'b000, 1'b0, 3'b100);
    tick(1); applyStimulus(3'b000, 1'b0, 3'b000);
    checkOutput("col_overflow_kept", overflow, 3'b100);
    applyStimulus(3'b000, 1'b1, 3'b000); tick(4);
    log_q.delete();

    // Reset in the middle of a hold with an event in flight
    applyReset();
    applyStimulus(3'b010, 1'b0, 3'b000);
    tick(5);
    checkOutput("rst_pre_valid", evt_if.evt_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_valid", evt_if.evt_valid, 0);
    checkOutput("rst_btn", evt_if.evt_btn, 0);
    tick(1);
    log_q.delete();
    evt_if.evt_ready = 1'b1;
    reset = 1'b0; x = cyc;
    tick(12);
    applyStimulus(3'b000, 1'b1, 3'b000); tick(4);
    expectEvt(1, PRESS, x + 2); expectEvt(1, LONG, x + 10); expectEvt(1, REL, x + 14);
    compareLog("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Per-button event sequencer and arbiter that sits behind the input debouncer. It converts each debounced, active-high button level into PRESS / LONG / REPEAT / RELEASE events and buffers one pending event per button. A round-robin arbiter then delivers the events over a single valid/ready channel to the control logic.

## Interface
- WIDTH, 3: number of buttons; must be ≥2.
- IDX_WIDTH, 2: width of evt_btn; must satisfy 2^IDX_WIDTH ≥ WIDTH.
- LONG_TIMEOUT, 25000000: cycles held before LONG; must be ≥2.
- REPEAT_PERIOD, 5000000: cycles between REPEAT events; must be ≥1.
- CNT_WIDTH, 25: counter width; must hold max(LONG_TIMEOUT, REPEAT_PERIOD)-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_level  in  WIDTH  debounced level, 1 = pressed.
- evt_valid  out  1  event available on evt_btn/evt_type.
- evt_ready  in  1  consumer accepts when evt_valid & evt_ready.
- evt_btn  out  IDX_WIDTH  index of the originating button.
- evt_type  out  2  event type: 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
- overflow  out  WIDTH  sticky flag, set when an event was dropped for that button.
- clr_overflow  in  WIDTH  clears the matching overflow bits.

## Operation
- Each button has its own FSM with states IDLE, HELD and RPT, plus a CNT_WIDTH counter.
- IDLE, level=1: emit PRESS; go to HELD; cnt←0. In IDLE the counter holds at 0.
- HELD, level=0: emit RELEASE; go to IDLE.
- HELD, level=1, cnt==LONG_TIMEOUT-1: emit LONG; go to RPT; cnt←0.
- HELD, level=1, otherwise: cnt←cnt+1.
- RPT, level=0: emit RELEASE; go to IDLE.
- RPT, level=1, cnt==REPEAT_PERIOD-1: emit REPEAT; cnt←0.
- RPT, level=1, otherwise: cnt←cnt+1.
- RELEASE has priority over LONG and REPEAT in the same cycle.
- No prior-level register is used: a button already high when reset deasserts produces a PRESS.
- Pending slot: one per button, holding pend[i] and ptype[i].
  - An emitted event loads the slot if the slot is empty, or if it is being transferred out in the same cycle.
  - Otherwise the new event is dropped, the old event is kept, and overflow[i] is set.
- Output register: evt_valid, evt_btn and evt_type.
  - It loads when it is empty, or when evt_valid & evt_ready.
  - Source is the first pend[j] set, searching from last_grant+1 and wrapping modulo WIDTH.
  - On load: pend[j] is cleared and last_grant←j.
  - If no slot is pending, evt_valid←0.
- Overflow: set and clear in the same cycle leaves the bit set.

## Timing
- Reset values:
  - evt_valid=0, evt_btn=0, evt_type=0, overflow=0.
  - All FSMs in IDLE, all counters 0, all pend=0.
  - last_grant=WIDTH-1, so button 0 is searched first.
- Latency: an event decided at edge k is in its slot after edge k; evt_valid rises after edge k+1, if the output register is free.
- Throughput: one event per cycle while evt_ready=1.
- evt_btn and evt_type stay stable while evt_valid & !evt_ready; evt_valid never drops without a handshake.
- Buffering is two-deep per button (pending slot plus output register), but only when the output register holds that button's event.
- LONG is emitted LONG_TIMEOUT cycles after PRESS. REPEAT follows every REPEAT_PERIOD cycles after that.
- Reset asserted mid-operation returns everything to reset values immediately. Pending and in-flight events are discarded, with no handshake.

## Test plan
Parameters for all scenarios: WIDTH=3, LONG_TIMEOUT=8, REPEAT_PERIOD=4, evt_ready=1.
- Tap: btn_level[0] high for 3 cycles -> PRESS(0) 2 cycles after the rise, then RELEASE(0); no LONG; overflow=0.
- Hold: btn_level[1] high from edge 0 to edge 20 -> events at edges 0, 8, 12, 16, 20 are PRESS, LONG, REPEAT, REPEAT, RELEASE. The release at edge 20 coincides with a REPEAT point, and RELEASE must win.
- Round-robin: all 3 buttons rise in the same cycle -> PRESS delivered for btn 0, 1, 2 on consecutive cycles. A second simultaneous round after the grant to btn 2 is delivered again in order 0, 1, 2.
- Backpressure: evt_ready=0, btn_level[2] tapped twice -> event 1 in the output register and event 2 pending; the third event is dropped and overflow[2]=1. With ready=1, PRESS then RELEASE are delivered with stable payload. clr_overflow[2] then clears the flag.
- Reset mid-hold: reset asserted at cycle 5 of a hold -> evt_valid=0 and pend=0 immediately. After deassert with the level still high -> fresh PRESS, and LONG arrives 8 cycles later.
- Overflow set/clear collision: drop event with clr_overflow[2]=1 in the same cycle -> overflow[2] remains 1.
